// File: rtl/ikaopm_dac.sv
// ----------------------------------------------------------------------------
// ikaopm_dac
//
// Receiver for the YM3012-style serial DAC interface. A 1-bit SO stream is
// shifted in LSB first, one bit per enabled cycle. Falling edges of the two
// sample-hold strobes latch the last 16 received bits as a 13-bit
// floating-point word: 10-bit mantissa with an inverted sign bit, plus a
// 3-bit exponent. The word is expanded to a signed 16-bit linear sample for
// the selected channel.
//
// Parameters
//   SH1_IS_LEFT   0: SH1 loads right and SH2 loads left; 1: swapped
//
// Ports
//   i_EMUCLK        master clock, all state updates on its rising edge
//   i_MRST_n        asynchronous active-low reset
//   i_phi1_NCEN_n   active-low clock enable, one serial bit slot per enable
//   i_SO            serial sound data, LSB first
//   i_SH1, i_SH2    sample-hold strobes, falling edge loads a channel
//   o_R, o_L        signed 16-bit right / left samples
//   o_R_VALID       high for one enable period after o_R loads
//   o_L_VALID       high for one enable period after o_L loads
//   o_ERR           sticky flags: [0] framing error, [1] zero-exponent word
// ----------------------------------------------------------------------------
module ikaopm_dac #(
    parameter logic SH1_IS_LEFT = 1'b0
) (
    input  logic        i_EMUCLK,
    input  logic        i_MRST_n,
    input  logic        i_phi1_NCEN_n,
    input  logic        i_SO,
    input  logic        i_SH1,
    input  logic        i_SH2,
    output logic [15:0] o_R,
    output logic [15:0] o_L,
    output logic        o_R_VALID,
    output logic        o_L_VALID,
    output logic [1:0]  o_ERR
);

    localparam logic [4:0] FRAME_LEN  = 5'd16;
    localparam logic [4:0] BITCNT_MAX = 5'd31;

    logic        en;

    logic [15:0] sr_q, sr_d;
    logic        sh1_q, sh1_d;
    logic        sh2_q, sh2_d;
    logic [4:0]  bitcnt_q, bitcnt_d;
    logic        first_edge_q, first_edge_d;
    logic [15:0] r_q, r_d;
    logic [15:0] l_q, l_d;
    logic        r_valid_q, r_valid_d;
    logic        l_valid_q, l_valid_d;
    logic [1:0]  err_q, err_d;

    logic [2:0]         exp_w;
    logic [2:0]         shamt;
    logic signed [15:0] mant_ext;
    logic signed [15:0] word;

    logic fall1, fall2, any_edge;
    logic load_r, load_l;

    assign en = ~i_phi1_NCEN_n;

    // Decode from the pre-shift register contents. The stored sign bit is
    // 1 for positive, so inverting it gives the two's-complement MSB of the
    // 10-bit mantissa. A shift of at most 6 keeps the result inside 16 bits.
    assign exp_w    = sr_q[12:10];
    assign shamt    = exp_w - 3'd1;
    assign mant_ext = {{6{~sr_q[9]}}, ~sr_q[9], sr_q[8:0]};
    assign word     = (exp_w == 3'd0) ? 16'sd0 : (mant_ext <<< shamt);

    assign fall1    = sh1_q & ~i_SH1;
    assign fall2    = sh2_q & ~i_SH2;
    assign any_edge = fall1 | fall2;

    assign load_r = SH1_IS_LEFT ? fall2 : fall1;
    assign load_l = SH1_IS_LEFT ? fall1 : fall2;

    always_comb begin
        sr_d         = sr_q;
        sh1_d        = sh1_q;
        sh2_d        = sh2_q;
        bitcnt_d     = bitcnt_q;
        first_edge_d = first_edge_q;
        r_d          = r_q;
        l_d          = l_q;
        r_valid_d    = r_valid_q;
        l_valid_d    = l_valid_q;
        err_d        = err_q;

        if (en) begin
            sr_d      = {i_SO, sr_q[15:1]};
            sh1_d     = i_SH1;
            sh2_d     = i_SH2;
            r_valid_d = load_r;
            l_valid_d = load_l;

            if (load_r) begin
                r_d = word;
            end
            if (load_l) begin
                l_d = word;
            end

            // A double edge on one enable is a single frame boundary, so it
            // performs one framing check and one counter reload.
            if (any_edge) begin
                bitcnt_d     = 5'd1;
                first_edge_d = 1'b0;
                if (!first_edge_q && (bitcnt_q != FRAME_LEN)) begin
                    err_d[0] = 1'b1;
                end
                if (exp_w == 3'd0) begin
                    err_d[1] = 1'b1;
                end
            end else if (bitcnt_q != BITCNT_MAX) begin
                bitcnt_d = bitcnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            sr_q         <= 16'h0000;
            sh1_q        <= 1'b0;
            sh2_q        <= 1'b0;
            bitcnt_q     <= 5'd0;
            first_edge_q <= 1'b1;
            r_q          <= 16'h0000;
            l_q          <= 16'h0000;
            r_valid_q    <= 1'b0;
            l_valid_q    <= 1'b0;
            err_q        <= 2'b00;
        end else begin
            sr_q         <= sr_d;
            sh1_q        <= sh1_d;
            sh2_q        <= sh2_d;
            bitcnt_q     <= bitcnt_d;
            first_edge_q <= first_edge_d;
            r_q          <= r_d;
            l_q          <= l_d;
            r_valid_q    <= r_valid_d;
            l_valid_q    <= l_valid_d;
            err_q        <= err_d;
        end
    end

    assign o_R       = r_q;
    assign o_L       = l_q;
    assign o_R_VALID = r_valid_q;
    assign o_L_VALID = l_valid_q;
    assign o_ERR     = err_q;

endmodule

// File: tb/tb_ikaopm_dac.sv
// Testbench for ikaopm_dac: two instances (normal and swapped channel map)
// share one stimulus stream; a monitor pops expected samples from per-channel
// queues whenever a VALID is seen.
module tb_ikaopm_dac;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ncen = 1'b1;
    logic so = 1'b0;
    logic sh1 = 1'b0;
    logic sh2 = 1'b0;

    logic [15:0] r0, l0, r1, l1;
    logic        rv0, lv0, rv1, lv1;
    logic [1:0]  err0, err1;

    int checks = 0;
    int failures = 0;

    logic [15:0] hist;
    logic        p1, p2;
    logic        pf1, pf2;
    bit          gaps;

    logic [15:0] q_r0[$];
    logic [15:0] q_l0[$];
    logic [15:0] q_r1[$];
    logic [15:0] q_l1[$];

    always #5 clk = ~clk;

    ikaopm_dac #(.SH1_IS_LEFT(1'b0)) dut0 (
        .i_EMUCLK(clk), .i_MRST_n(rst_n), .i_phi1_NCEN_n(ncen), .i_SO(so),
        .i_SH1(sh1), .i_SH2(sh2), .o_R(r0), .o_L(l0),
        .o_R_VALID(rv0), .o_L_VALID(lv0), .o_ERR(err0)
    );

    ikaopm_dac #(.SH1_IS_LEFT(1'b1)) dut1 (
        .i_EMUCLK(clk), .i_MRST_n(rst_n), .i_phi1_NCEN_n(ncen), .i_SO(so),
        .i_SH1(sh1), .i_SH2(sh2), .o_R(r1), .o_L(l1),
        .o_R_VALID(rv1), .o_L_VALID(lv1), .o_ERR(err1)
    );

    // Reference decode in plain integer arithmetic.
    function automatic logic [15:0] model(input logic [15:0] h);
        int mant, sgn, e, v;
        mant = int'(h[8:0]);
        sgn  = int'(h[9]);
        e    = int'(h[12:10]);
        if (e == 0) return 16'h0000;
        v = (sgn == 1) ? mant : mant - 512;
        v = v * (2 ** (e - 1));
        return v[15:0];
    endfunction

    function automatic logic [15:0] mk(input logic sgn, input logic [8:0] mant,
                                       input logic [2:0] e);
        logic [2:0] pad;
        pad = 3'($urandom);
        return {pad, e, sgn, mant};
    endfunction

    // Monitor: every enabled cycle, each asserted VALID must match the oldest
    // expected sample for that channel.
    logic        mon_en;
    logic [15:0] mon_exp;
    always @(posedge clk) begin
        mon_en = rst_n && !ncen;
        #1;
        if (mon_en) begin
            if (rv0) begin
                checks++;
                if (q_r0.size() == 0) begin
                    failures++;
                    $display("FAIL dut0_R unexpected valid, got %h expected none", r0);
                end else begin
                    mon_exp = q_r0.pop_front();
                    if (r0 !== mon_exp) begin
                        failures++;
                        $display("FAIL dut0_R got %h expected %h", r0, mon_exp);
                    end
                end
            end
            if (lv0) begin
                checks++;
                if (q_l0.size() == 0) begin
                    failures++;
                    $display("FAIL dut0_L unexpected valid, got %h expected none", l0);
                end else begin
                    mon_exp = q_l0.pop_front();
                    if (l0 !== mon_exp) begin
                        failures++;
                        $display("FAIL dut0_L got %h expected %h", l0, mon_exp);
                    end
                end
            end
            if (rv1) begin
                checks++;
                if (q_r1.size() == 0) begin
                    failures++;
                    $display("FAIL dut1_R unexpected valid, got %h expected none", r1);
                end else begin
                    mon_exp = q_r1.pop_front();
                    if (r1 !== mon_exp) begin
                        failures++;
                        $display("FAIL dut1_R got %h expected %h", r1, mon_exp);
                    end
                end
            end
            if (lv1) begin
                checks++;
                if (q_l1.size() == 0) begin
                    failures++;
                    $display("FAIL dut1_L unexpected valid, got %h expected none", l1);
                end else begin
                    mon_exp = q_l1.pop_front();
                    if (l1 !== mon_exp) begin
                        failures++;
                        $display("FAIL dut1_L got %h expected %h", l1, mon_exp);
                    end
                end
            end
        end
    end

    // One enabled bit slot; optionally followed by a disabled cycle carrying
    // junk inputs, across which all outputs must hold.
    task automatic slot(input logic b, input logic s1, input logic s2);
        logic f1, f2;
        logic [15:0] v, hr, hl;
        logic hrv, hlv;
        ncen = 1'b0;
        so   = b;
        sh1  = s1;
        sh2  = s2;
        f1 = p1 & ~s1;
        f2 = p2 & ~s2;
        if (f1 || f2) begin
            v = model(hist);
            if (f1) begin
                q_r0.push_back(v);
                q_l1.push_back(v);
            end
            if (f2) begin
                q_l0.push_back(v);
                q_r1.push_back(v);
            end
        end
        hist = {b, hist[15:1]};
        p1 = s1;
        p2 = s2;
        @(posedge clk);
        #2;
        if (gaps) begin
            hr = r0; hl = l0; hrv = rv0; hlv = lv0;
            ncen = 1'b1;
            so   = 1'($urandom);
            sh1  = 1'($urandom);
            sh2  = 1'($urandom);
            @(posedge clk);
            #2;
            checks++;
            if ({r0, l0, rv0, lv0} !== {hr, hl, hrv, hlv}) begin
                failures++;
                $display("FAIL hold_disabled got %h_%h_%b%b expected %h_%h_%b%b",
                         r0, l0, rv0, lv0, hr, hl, hrv, hlv);
            end
        end
    endtask

    // Sends n bits of w; the strobe edge pending from the previous word is
    // placed on this word's first bit slot.
    task automatic send_word(input logic [15:0] w, input logic f1, input logic f2,
                             input int n = 16);
        for (int i = 0; i < n; i++) begin
            slot(w[i], (i == 0 && pf1) ? 1'b0 : 1'b1, (i == 0 && pf2) ? 1'b0 : 1'b1);
        end
        pf1 = f1;
        pf2 = f2;
    endtask

    task automatic flush();
        slot(1'($urandom), pf1 ? 1'b0 : 1'b1, pf2 ? 1'b0 : 1'b1);
        pf1 = 1'b0;
        pf2 = 1'b0;
    endtask

    task automatic do_reset();
        ncen  = 1'b1;
        rst_n = 1'b0;
        #3;
        checks++;
        if ({r0, l0, rv0, lv0, err0, r1, l1, rv1, lv1, err1} !== 70'd0) begin
            failures++;
            $display("FAIL reset_outputs got %h_%h_%b%b_%b expected all zero",
                     r0, l0, rv0, lv0, err0);
        end
        hist = 16'h0000;
        p1 = 1'b0; p2 = 1'b0;
        pf1 = 1'b0; pf2 = 1'b0;
        gaps = 1'b0;
        sh1 = 1'b0; sh2 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        slot(1'b0, 1'b0, 1'b0);
        slot(1'b1, 1'b0, 1'b0);
        slot(1'b0, 1'b1, 1'b1);
        slot(1'b1, 1'b1, 1'b1);
        checks++;
        if ({rv0, lv0, err0} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_no_edge got valid=%b%b err=%b expected 00 00", rv0, lv0, err0);
        end
    endtask

    task automatic test_decode();
        do_reset();
        send_word(mk(1'b1, 9'h1FF, 3'd7), 1'b1, 1'b0);
        send_word(mk(1'b0, 9'h000, 3'd7), 1'b0, 1'b1);
        checks++;
        if (r0 !== 16'h7FC0 || err0 !== 2'b00) begin
            failures++;
            $display("FAIL pos_max got %h err=%b expected 7fc0 err=00", r0, err0);
        end
        send_word(mk(1'b0, 9'h1FF, 3'd1), 1'b0, 1'b1);
        checks++;
        if (l0 !== 16'h8000) begin
            failures++;
            $display("FAIL neg_max got %h expected 8000", l0);
        end
        send_word(mk(1'b1, 9'h005, 3'd1), 1'b1, 1'b0);
        checks++;
        if (l0 !== 16'hFFFF) begin
            failures++;
            $display("FAIL minus_one got %h expected ffff", l0);
        end
        send_word(mk(1'b1, 9'h005, 3'd4), 1'b1, 1'b0);
        checks++;
        if (r0 !== 16'h0005 || l1 !== 16'h0005) begin
            failures++;
            $display("FAIL small_e1 got r0=%h l1=%h expected 0005", r0, l1);
        end
        flush();
        checks++;
        if (r0 !== 16'h0028 || l1 !== 16'h0028 || err0 !== 2'b00) begin
            failures++;
            $display("FAIL small_e4 got r0=%h l1=%h err=%b expected 0028 err=00", r0, l1, err0);
        end
        checks++;
        if (q_r0.size() + q_l0.size() + q_r1.size() + q_l1.size() != 0) begin
            failures++;
            $display("FAIL decode_drain got %0d pending expected 0",
                     q_r0.size() + q_l0.size() + q_r1.size() + q_l1.size());
        end
    endtask

    task automatic test_framing();
        do_reset();
        send_word(mk(1'b1, 9'h100, 3'd5), 1'b1, 1'b0);
        send_word(mk(1'b0, 9'h0F0, 3'd3), 1'b0, 1'b1);
        send_word(mk(1'b1, 9'h011, 3'd2), 1'b1, 1'b0, 15);
        checks++;
        if (err0 !== 2'b00) begin
            failures++;
            $display("FAIL frame_ok got err=%b expected 00", err0);
        end
        send_word(mk(1'b1, 9'h033, 3'd6), 1'b0, 1'b1);
        checks++;
        if (err0 !== 2'b01 || err1 !== 2'b01) begin
            failures++;
            $display("FAIL frame_short got err=%b/%b expected 01", err0, err1);
        end
        send_word(mk(1'b0, 9'h1A5, 3'd4), 1'b1, 1'b0);
        flush();
        checks++;
        if (err0 !== 2'b01) begin
            failures++;
            $display("FAIL frame_sticky got err=%b expected 01", err0);
        end
        checks++;
        if (q_r0.size() + q_l0.size() + q_r1.size() + q_l1.size() != 0) begin
            failures++;
            $display("FAIL framing_drain got %0d pending expected 0",
                     q_r0.size() + q_l0.size() + q_r1.size() + q_l1.size());
        end
    endtask

    task automatic test_zero_exp();
        do_reset();
        send_word(mk(1'b1, 9'h077, 3'd5), 1'b1, 1'b0);
        send_word(mk(1'b1, 9'h1F3, 3'd0), 1'b1, 1'b0);
        send_word(mk(1'b1, 9'h0AB, 3'd3), 1'b1, 1'b1);
        checks++;
        if (r0 !== 16'h0000 || err0 !== 2'b10) begin
            failures++;
            $display("FAIL zero_exp got %h err=%b expected 0000 err=10", r0, err0);
        end
        send_word(mk(1'b0, 9'h010, 3'd2), 1'b1, 1'b0);
        checks++;
        if (r0 !== 16'h02AC || l0 !== 16'h02AC) begin
            failures++;
            $display("FAIL double_edge got r=%h l=%h expected 02ac", r0, l0);
        end
        flush();
        checks++;
        if (err0 !== 2'b10) begin
            failures++;
            $display("FAIL double_edge_check got err=%b expected 10", err0);
        end
        checks++;
        if (q_r0.size() + q_l0.size() + q_r1.size() + q_l1.size() != 0) begin
            failures++;
            $display("FAIL zero_drain got %0d pending expected 0",
                     q_r0.size() + q_l0.size() + q_r1.size() + q_l1.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_word(mk(1'b1, 9'h010, 3'd0), 1'b1, 1'b0);
        send_word(mk(1'b1, 9'h003, 3'd2), 1'b1, 1'b0);
        send_word(mk(1'b0, 9'h155, 3'd6), 1'b0, 1'b1, 7);
        checks++;
        if (r0 !== 16'h0006 || err0 !== 2'b10) begin
            failures++;
            $display("FAIL pre_reset got %h err=%b expected 0006 err=10", r0, err0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({r0, l0, rv0, lv0, err0} !== 35'd0) begin
            failures++;
            $display("FAIL reset_async got %h_%h_%b%b_%b expected all zero",
                     r0, l0, rv0, lv0, err0);
        end
        do_reset();
        send_word(16'h03F5, 1'b1, 1'b0, 10);
        flush();
        checks++;
        if (err0 !== 2'b00 || r0 !== 16'hD000) begin
            failures++;
            $display("FAIL first_edge got %h err=%b expected d000 err=00", r0, err0);
        end
    endtask

    task automatic test_back_to_back();
        int sel;
        do_reset();
        gaps = 1'b1;
        for (int k = 0; k < 12; k++) begin
            sel = $urandom_range(1, 3);
            send_word(mk(1'($urandom), 9'($urandom), 3'($urandom_range(1, 7))),
                      sel[0], sel[1]);
        end
        flush();
        gaps = 1'b0;
        checks++;
        if (err0 !== 2'b00 || err1 !== 2'b00) begin
            failures++;
            $display("FAIL b2b_err got %b/%b expected 00", err0, err1);
        end
        checks++;
        if (q_r0.size() + q_l0.size() + q_r1.size() + q_l1.size() != 0) begin
            failures++;
            $display("FAIL b2b_drain got %0d pending expected 0",
                     q_r0.size() + q_l0.size() + q_r1.size() + q_l1.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_decode();
        test_framing();
        test_zero_exp();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ikaopm_dac.md
# ikaopm_dac

Serial floating-point sound receiver and decoder that sits directly downstream of the accumulator/serialiser stage. It consumes the 1-bit SO stream and the two sample-hold strobes SH1/SH2, the interface a YM3012-style DAC sees. It converts each 13-bit floating-point word to a signed 16-bit linear sample per channel. It also flags framing and format errors.

## Interface
- SH1_IS_LEFT, default 0: 0 = SH1 falling edge loads right channel and SH2 loads left; 1 = swapped.
- i_EMUCLK  in  1  emulator master clock; all state updates on posedge.
- i_MRST_n  in  1  asynchronous, active-low reset; clears all state immediately.
- i_phi1_NCEN_n  in  1  active-low clock enable; one serial bit slot per enabled cycle.
- i_SO  in  1  serial sound data, one bit per enabled cycle, LSB first.
- i_SH1  in  1  sample-hold strobe 1, sampled on enabled cycles only.
- i_SH2  in  1  sample-hold strobe 2, sampled on enabled cycles only.
- o_R  out  16  signed right sample; reset 0.
- o_L  out  16  signed left sample; reset 0.
- o_R_VALID  out  1  high for one enable period after o_R updates; reset 0.
- o_L_VALID  out  1  high for one enable period after o_L updates; reset 0.
- o_ERR  out  2  sticky: [0] framing error, [1] zero-exponent word; reset 2'b00.

## Operation
- All registers other than the async reset update only on posedge i_EMUCLK with i_phi1_NCEN_n low. Disabled cycles hold all state, including the VALID outputs.
- Shift register sr[15:0]: each enable does sr <= {i_SO, sr[15:1]}. The oldest bit ends up in sr[0].
- Frame layout at a strobe edge, before that enable's shift:
  - sr[8:0]: mantissa low bits.
  - sr[9]: sign, where 1 = positive.
  - sr[12:10]: exponent.
  - sr[15:13]: padding, ignored.
- Edge detect: registers sh1_d and sh2_d hold the previous enabled sample of each strobe. A falling edge is sh_d=1 with the current strobe=0.
- Decode, all combinational from pre-shift sr:
  - m = signed 10-bit {~sr[9], sr[8:0]}.
  - e = sr[12:10].
  - If e ≠ 0: out = sign-extend(m) <<< (e−1), exactly 16 bits with no overflow possible.
  - If e = 0: out = 0 and o_ERR[1] is set.
- Channel load:
  - An SH1 falling edge loads the decoded word into R, or into L when SH1_IS_LEFT=1.
  - An SH2 falling edge loads the other channel.
  - The loaded channel's VALID is set on that enable. Each VALID clears on the next enable that has no edge for its channel.
- Both edges on the same enable: both channels load the same word, and both VALIDs assert.
- Framing counter bitcnt[4:0]:
  - Increments each enable and saturates at 31.
  - On any SH falling edge it is compared to 16, then reloaded to 1.
  - A mismatch sets o_ERR[0]. This check is skipped for the first edge after reset, tracked by a first_edge flag.
  - A same-enable double edge counts as one check.
- o_ERR bits clear only on reset. A sample is still loaded when an error is flagged.
- Strobe sampled high with no prior low, including the first enable after reset: sh_d resets to 0, so no edge is seen.

## Timing
- Latency: a falling edge sampled on enable N gives o_R/o_L and VALID valid after posedge N. The decoded word is the 16 bits received on enables N−16 … N−1.
- Sustained rate: one word per 16 enables per strobe. The strobes are typically offset by 16 enables (R at 13, L at 29 in a 32-slot cycle); any offset is accepted.
- Reset asserted mid-frame:
  - Outputs, sr, bitcnt, sh_d and o_ERR clear asynchronously, and first_edge is set.
  - After release, the first edge is accepted without a framing check.

## Test plan
- Positive max: frame sign=1, mantissa 0x1FF, e=7, then SH1 falls → o_R = 0x7FC0 (32704), o_R_VALID high for one enable, o_ERR=0.
- Negative max: sign=0, mantissa 0x000, e=7, SH2 falls → o_L = 0x8000 (−32768). Then sign=0, mantissa 0x1FF, e=1 → o_L = 0xFFFF (−1).
- Small/shift: sign=1, mantissa 0x005, e=1 → 5; same mantissa with e=4 → 40. Check with SH1_IS_LEFT=1 that the value lands on o_L.
- Framing: edges 16 enables apart, then one gap of 15 enables → o_ERR[0]=1 from that edge onward, sample still loaded. It stays set through later correct frames until reset.
- Zero exponent: e=0 with any mantissa → channel output 0, o_ERR[1]=1. Simultaneous SH1/SH2 edge → both channels get the same value, single framing check.
- Reset mid-frame at enable 7 → all outputs 0 immediately, with no clock needed. The next edge after release is not flagged even if fewer than 16 enables have elapsed.
